// File: rtl/proc_defs.sv
// Shared processor definitions: sizes, opcodes, IR field layout,
// fetch state encoding and an opcode extraction helper.
package proc_defs;

    localparam int AW         = 4;
    localparam int DW         = 32;
    localparam int IMEM_DEPTH = 16;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int ISRC_MSB  = 15;
    localparam int ISRC_LSB  = 0;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HALT
    } fetch_state_t;

    function automatic logic [4:0] opcode_of(input logic [DW-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction register handshake: master drives ir_valid/ir_data/ir_pc,
// slave drives ir_ready.
interface inst_fetch_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          ir_valid;
    logic          ir_ready;
    logic [DW-1:0] ir_data;
    logic [AW-1:0] ir_pc;

    modport master (
        output ir_valid, ir_data, ir_pc,
        input  ir_ready
    );

    modport slave (
        input  ir_valid, ir_data, ir_pc,
        output ir_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Two-entry fetch FIFO with flush.
// Ports: push/push_data in, pop, flush; head = oldest entry, count = occupancy.
module fetch_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;

    assign head = slot[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: program-loadable IMEM, PC sequencing, 2-deep IR FIFO.
// Ports: load_*, run, redirect_*, ir (master handshake), halted, busy, fetch_count.
module inst_fetch #(
    parameter int IMEM_DEPTH = 16,
    parameter int AW         = 4,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          run,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    inst_fetch_if.master  ir,
    output logic          halted,
    output logic          busy,
    output logic [15:0]   fetch_count
);
    import proc_defs::*;

    localparam int FW = DW + AW;

    fetch_state_t  state;
    logic [DW-1:0] imem [IMEM_DEPTH];
    logic [AW-1:0] pc;
    logic [AW-1:0] rd_pc;
    logic [DW-1:0] rd_data;
    logic          inflight;
    logic [1:0]    fifo_count;
    logic [FW-1:0] fifo_head;
    logic          pop;
    logic          push;
    logic          flush;
    logic          redir;
    logic          halt_acc;
    logic          issue;
    logic [2:0]    occ;

    assign ir.ir_valid = (fifo_count != 2'd0);
    assign ir.ir_data  = fifo_head[FW-1:AW];
    assign ir.ir_pc    = fifo_head[AW-1:0];

    assign pop      = ir.ir_valid && ir.ir_ready;
    assign redir    = redirect_valid && (state != ST_IDLE);
    assign halt_acc = pop && (state == ST_FETCH) && !redir
                      && (opcode_of(ir.ir_data) == OP_HALT);
    assign flush    = redir || halt_acc;
    // A flush also drops the read in flight.
    assign push     = inflight && !flush;
    // Occupancy after this edge's pop must leave room for the new read.
    assign occ      = {1'b0, fifo_count} + {2'b0, inflight};
    assign issue    = (state == ST_FETCH) && !flush
                      && (occ < (3'd2 + {2'b0, pop}));

    assign halted = (state == ST_HALT);
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (load_en && state == ST_IDLE) imem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= '0;
            rd_pc       <= '0;
            rd_data     <= '0;
            inflight    <= 1'b0;
            fetch_count <= '0;
        end else begin
            inflight <= issue;
            if (pop) fetch_count <= fetch_count + 16'd1;
            if (issue) begin
                rd_data <= imem[pc];
                rd_pc   <= pc;
                pc      <= pc + AW'(1);
            end
            unique case (1'b1)
                redir: begin
                    state <= ST_FETCH;
                    pc    <= redirect_pc;
                end
                (state == ST_IDLE && run): begin
                    state <= ST_FETCH;
                    pc    <= '0;
                end
                halt_acc: state <= ST_HALT;
                default: ;
            endcase
        end
    end

    fetch_fifo #(.W(FW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rd_data, rd_pc}),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic,
// checked against a transaction-level model of the fetch stream.
module tb_inst_fetch;
    import proc_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        run = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [3:0]  redirect_pc = '0;
    logic        halted;
    logic        busy;
    logic [15:0] fetch_count;

    inst_fetch_if #(.AW(4), .DW(32)) irb ();

    inst_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir             (irb.master),
        .halted         (halted),
        .busy           (busy),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          m_st = 0;
    logic [3:0]  m_pc = '0;
    logic [3:0]  m_tgt = '0;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_mem [16];
    int          lat = 99;
    bit          stall = 0;
    bit          stream = 0;
    logic [31:0] s_data;
    logic [3:0]  s_pc;
    logic [31:0] prog [4] = '{32'h0840_0005, 32'h0880_0003,
                              32'h10C2_0800, 32'hF800_0000};
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        v;
        logic [31:0] d;
        logic [3:0]  p;
        bit          acc;
        @(negedge clk);
        v = irb.ir_valid;
        d = irb.ir_data;
        p = irb.ir_pc;
        if (lat < 10) lat++;
        chk("halted", 32'(halted), 32'(m_st == 2));
        chk("busy", 32'(busy), 32'(m_st != 0));
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
        if (m_st != 1) chk("valid_not_fetch", 32'(v), 0);
        if (stall) begin
            chk("stall_valid", 32'(v), 1);
            chk("stall_data", d, s_data);
            chk("stall_pc", 32'(p), 32'(s_pc));
        end
        if (m_st == 1 && lat == 1) chk("lat1_valid", 32'(v), 0);
        if (m_st == 1 && lat == 2) chk("lat2_valid", 32'(v), 0);
        if (m_st == 1 && lat == 3) begin
            chk("lat3_valid", 32'(v), 1);
            chk("lat3_pc", 32'(p), 32'(m_tgt));
        end
        if (stream && m_st == 1 && lat >= 3) chk("stream_valid", 32'(v), 1);
        acc = v && irb.ir_ready;
        stall = v && !irb.ir_ready && !(m_st != 0 && redirect_valid);
        s_data = d;
        s_pc = p;
        if (acc) begin
            chk("acc_pc", 32'(p), 32'(m_pc));
            chk("acc_data", d, m_mem[m_pc]);
            m_cnt++;
            m_pc++;
        end
        if (m_st == 0) begin
            if (load_en) m_mem[load_addr] = load_data;
            if (run) begin
                m_st = 1; m_pc = '0; m_tgt = '0; lat = 0;
            end
        end else if (redirect_valid) begin
            m_st = 1; m_pc = redirect_pc; m_tgt = redirect_pc; lat = 0;
        end else if (acc && d[31:27] == OP_HALT) begin
            m_st = 2;
        end
        @(posedge clk);
        #1;
        run = 1'b0;
        redirect_valid = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(irb.ir_valid), 0);
        chk("rst_data", irb.ir_data, 0);
        chk("rst_pc", 32'(irb.ir_pc), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_count", 32'(fetch_count), 0);
        m_st = 0; m_cnt = '0; lat = 99; stall = 0; stream = 0;
        #1 rst_n = 1'b1;
    endtask

    task automatic load(input logic [3:0] a, input logic [31:0] w,
                        input bit go);
        load_en = 1'b1;
        load_addr = a;
        load_data = w;
        run = go;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bit          found;
        irb.ir_ready = 1'b0;
        @(posedge clk);
        #1;
        async_reset();

        // Small program ending in HALT; word 0 written with run.
        for (int i = 1; i < 4; i++) load(4'(i), prog[i], 1'b0);
        irb.ir_ready = 1'b1;
        stream = 1;
        load(4'd0, prog[0], 1'b1);
        repeat (8) tick();
        chk("halt_state", 32'(halted), 1);
        chk("halt_count", 32'(fetch_count), 4);

        // Leave HALT via redirect.
        redirect_valid = 1'b1;
        redirect_pc = 4'd1;
        tick();
        repeat (6) tick();
        chk("rehalt_count", 32'(fetch_count), 7);
        stream = 0;

        // Full memory of non-halt words, 20-cycle stream with wrap.
        async_reset();
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            if (w[31:27] == OP_HALT) w[31] = 1'b0;
            load(4'(i), w, 1'b0);
        end
        stream = 1;
        run = 1'b1;
        tick();
        tick();
        tick();
        repeat (20) tick();
        stream = 0;
        irb.ir_ready = 1'b0;
        tick();
        chk("thru_count", 32'(fetch_count), 20);

        // Stall pattern on ir_ready.
        for (int r = 0; r < 3; r++)
            for (int j = 0; j < 4; j++) begin
                irb.ir_ready = pat[j];
                tick();
            end

        // Redirect during FETCH.
        irb.ir_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 4'd9;
        tick();
        repeat (5) tick();

        // HALT at PC 2 accepted together with a redirect.
        async_reset();
        load(4'd2, {OP_HALT, 27'($urandom)}, 1'b0);
        irb.ir_ready = 1'b1;
        run = 1'b1;
        tick();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (irb.ir_valid && irb.ir_pc == 4'd2) begin
                found = 1;
                redirect_valid = 1'b1;
                redirect_pc = 4'd5;
            end
            tick();
        end
        chk("find_pc2", 32'(found), 1);
        repeat (4) tick();
        chk("no_halt", 32'(halted), 0);

        // Fill the FIFO with loads attempted in FETCH, then reset.
        irb.ir_ready = 1'b0;
        repeat (4) load(4'($urandom), $urandom, 1'b0);
        async_reset();

        // Random traffic over the retained memory.
        run = 1'b1;
        tick();
        repeat (400) begin
            irb.ir_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                load_en = 1'b1;
                load_addr = 4'($urandom);
                load_data = $urandom;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: IMEM_DEPTH, 16, instruction memory words; AW, 4, PC width; DW, 32, instruction width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 load_en  in  1  program-load write strobe.
REQ-005 load_addr  in  AW  program-load word address.
REQ-006 load_data  in  DW  program-load word.
REQ-007 run  in  1  start fetching from PC 0.
REQ-008 redirect_valid  in  1  PC redirect request.
REQ-009 redirect_pc  in  AW  redirect target.
REQ-010 ir_ready  in  1  downstream decode/execute stage accepts IR.
REQ-011 ir_valid  out  1  ir_data/ir_pc hold a fetched instruction.
REQ-012 ir_data  out  DW  instruction word, fields per IR layout: [31:27] opcode, [26:22] rdst, [21:17] rsrc1, [16] imm_mode, [15:0] isrc.
REQ-013 ir_pc  out  AW  address of ir_data.
REQ-014 halted  out  1  HALT state.
REQ-015 busy  out  1  state != IDLE.
REQ-016 fetch_count  out  16  number of accepted instructions.

Function
REQ-017 States IDLE, FETCH, HALT; IDLE->FETCH on run; FETCH->HALT on acceptance (ir_valid && ir_ready) of opcode 5'b11111; HALT->FETCH on redirect_valid; no other transitions except reset.
REQ-018 Instruction memory: IMEM_DEPTH x DW, synchronous write, synchronous read, one-cycle read latency.
REQ-019 load_en writes load_data to load_addr only in IDLE; ignored in FETCH and HALT.
REQ-020 load_en and run in same IDLE cycle: write completes; first read (next cycle) returns new data.
REQ-021 On IDLE->FETCH, PC = 0.
REQ-022 In FETCH, a read issues at PC each cycle where (fifo_count + inflight - pop) < 2; PC then increments, wrapping 15->0.
REQ-023 Read data pushes into a 2-entry FIFO one cycle after issue, tagged with its PC; FIFO never overflows.
REQ-024 ir_valid = FIFO non-empty; ir_data/ir_pc = FIFO head; head pops on ir_valid && ir_ready.
REQ-025 ir_data/ir_pc stable while ir_valid && !ir_ready.
REQ-026 Sustained throughput 1 instruction/cycle with ir_ready held high.
REQ-027 Latency: run or redirect sampled at edge T -> ir_valid high after edge T+2.
REQ-028 redirect_valid in FETCH or HALT: FIFO and inflight read discarded, PC = redirect_pc, ir_valid low after that edge; ignored in IDLE.
REQ-029 redirect_valid and halt acceptance same cycle: redirect wins, state stays/returns FETCH, fetch_count still increments.
REQ-030 On entering HALT: FIFO flushed, inflight discarded, no further reads issued.
REQ-031 fetch_count increments by 1 per acceptance, wraps 16'hFFFF->0.
REQ-032 halted = (state == HALT); busy = (state != IDLE).

Reset
REQ-033 rst_n low asynchronously forces: state IDLE, PC 0, FIFO empty, inflight cleared, ir_valid 0, ir_data 0, ir_pc 0, halted 0, busy 0, fetch_count 0.
REQ-034 Instruction memory contents are not reset.
REQ-035 Reset mid-FETCH discards all in-progress fetches; outputs return to reset values immediately.

Structure
REQ-036 Shared package proc_defs holds AW, DW, opcode constants (including OP_HALT = 5'b11111) and IR field positions.
REQ-037 FIFO is sub-module fetch_fifo (2-entry, DW+AW wide, push/pop/flush, count output).

Verification
REQ-038 Load 0..3 = {32'h0840_0005, 32'h0880_0003, 32'h10C2_0800, 32'hF800_0000}, run, ir_ready=1 -> ir_pc 0,1,2,3 on consecutive cycles from T+2, halted after accept of PC 3, fetch_count=4.
REQ-039 Load 16 non-halt words, run, ir_ready=1 for 20 cycles -> ir_pc 0..15,0..3, one per cycle, fetch_count=20.
REQ-040 ir_ready toggled 1,0,0,1 -> ir_data held during stall, no skipped or duplicated PC.
REQ-041 redirect_valid, redirect_pc=9 during FETCH -> ir_valid low next cycle, next ir_pc=9 at T+2.
REQ-042 Halt at PC 2 accepted with redirect_pc=5 same cycle -> halted stays 0, next ir_pc=5.
REQ-043 rst_n low mid-FETCH with 2 FIFO entries -> ir_valid, busy, fetch_count 0 without a clock edge; load_en in FETCH leaves memory unchanged.
